// File: rtl/branch_predictor_sat.sv
// Direction predictor: 2^INDEX_BITS saturating counters indexed bimodally or gshare-style,
// cleared by a post-reset sweep, with a registered mispredict pulse and saturating statistics.
module branch_predictor_sat #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned GHR_BITS   = 4,
  parameter int unsigned MODE       = 0,
  parameter int unsigned CNT_BITS   = 16
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [0:31]         Lookup_Addr,
  output logic                Prediction,
  output logic [0:GHR_BITS-1] Lookup_GHR,
  input  logic                Update_Valid,
  input  logic [0:31]         Update_Addr,
  input  logic [0:GHR_BITS-1] Update_GHR,
  input  logic                Update_Pred,
  input  logic                Update_Taken,
  input  logic                Stat_Clear,
  output logic                Ready,
  output logic                Mispredict,
  output logic [0:CNT_BITS-1] Mispredict_Count
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;

  typedef logic [INDEX_BITS-1:0] idx_t;
  typedef logic [CTR_BITS-1:0]   ctr_t;

  localparam ctr_t WEAK_T  = ctr_t'(1) << (CTR_BITS - 1);
  localparam ctr_t CTR_MAX = '1;
  localparam idx_t IDX_END = idx_t'(DEPTH - 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t              state, state_nx;
  idx_t                sweep_idx;
  logic [GHR_BITS-1:0] ghr;
  logic [CNT_BITS-1:0] mis_cnt;
  ctr_t                table_q [DEPTH];

  idx_t lk_idx, upd_idx;
  ctr_t upd_cur, upd_nxt;
  logic upd_en;
  logic tbl_we;
  idx_t tbl_waddr;
  ctr_t tbl_wdata;

  // Port vectors are big-endian (bit 31 is the LSB); numeric values carry over unchanged.
  function automatic idx_t table_index(input logic [0:31] addr, input logic [GHR_BITS-1:0] g);
    idx_t a;
    a = addr[32-INDEX_BITS:31];
    if (MODE != 0) return a ^ idx_t'(g);
    return a;
  endfunction

  assign lk_idx  = table_index(Lookup_Addr, ghr);
  assign upd_idx = table_index(Update_Addr, Update_GHR);
  assign upd_en  = Update_Valid && (state == S_RUN);
  assign upd_cur = table_q[upd_idx];

  always_comb begin
    upd_nxt = upd_cur;
    if (Update_Taken) begin
      if (upd_cur != CTR_MAX) upd_nxt = upd_cur + ctr_t'(1);
    end else begin
      if (upd_cur != '0) upd_nxt = upd_cur - ctr_t'(1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:  if (sweep_idx == IDX_END) state_nx = S_RUN;
      S_RUN:   state_nx = S_RUN;
      default: state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_INIT;
      sweep_idx <= '0;
    end else begin
      state <= state_nx;
      if (state == S_INIT) sweep_idx <= sweep_idx + idx_t'(1);
    end
  end

  // Single write port: the sweep owns it in INIT, resolved branches in RUN.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = '0;
    tbl_wdata = '0;
    if (state == S_INIT) begin
      tbl_we    = 1'b1;
      tbl_waddr = sweep_idx;
      tbl_wdata = WEAK_T;
    end else if (upd_en) begin
      tbl_we    = 1'b1;
      tbl_waddr = upd_idx;
      tbl_wdata = upd_nxt;
    end
  end

  always_ff @(posedge Clock) begin
    if (tbl_we) table_q[tbl_waddr] <= tbl_wdata;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ghr        <= '0;
      Mispredict <= 1'b0;
      mis_cnt    <= '0;
    end else begin
      Mispredict <= upd_en && (Update_Pred != Update_Taken);
      if (upd_en) ghr <= (ghr << 1) | GHR_BITS'(Update_Taken);
      if (Stat_Clear)
        mis_cnt <= '0;
      else if (Mispredict && (mis_cnt != '1))
        mis_cnt <= mis_cnt + CNT_BITS'(1);
    end
  end

  assign Ready            = (state == S_RUN);
  assign Prediction       = (state == S_RUN) ? table_q[lk_idx][CTR_BITS-1] : 1'b1;
  assign Lookup_GHR       = ghr;
  assign Mispredict_Count = mis_cnt;

  logic unused_bits;
  assign unused_bits = ^{Lookup_Addr[0:31-INDEX_BITS], Update_Addr[0:31-INDEX_BITS], Update_GHR};

endmodule

// File: tb/tb_branch_predictor_sat.sv
// Directed bench: a bimodal instance (4-bit stats) and a gshare instance driven by the same stimulus.
module tb_branch_predictor_sat;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b1;
  logic [31:0] lookup_addr = '0;
  logic        update_valid = 1'b0;
  logic [31:0] update_addr = '0;
  logic [3:0]  update_ghr = '0;
  logic        update_pred = 1'b0;
  logic        update_taken = 1'b0;
  logic        stat_clear = 1'b0;

  logic        pred_b, ready_b, misp_b;
  logic [3:0]  ghr_b, cnt_b;
  logic        pred_g, ready_g, misp_g;
  logic [3:0]  ghr_g;
  logic [15:0] cnt_g;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  branch_predictor_sat #(.INDEX_BITS(4), .CTR_BITS(2), .GHR_BITS(4), .MODE(0), .CNT_BITS(4)) dut_bim (
    .Clock(Clock), .Reset_n(Reset_n), .Lookup_Addr(lookup_addr), .Prediction(pred_b),
    .Lookup_GHR(ghr_b), .Update_Valid(update_valid), .Update_Addr(update_addr),
    .Update_GHR(update_ghr), .Update_Pred(update_pred), .Update_Taken(update_taken),
    .Stat_Clear(stat_clear), .Ready(ready_b), .Mispredict(misp_b), .Mispredict_Count(cnt_b)
  );

  branch_predictor_sat #(.INDEX_BITS(4), .CTR_BITS(2), .GHR_BITS(4), .MODE(1), .CNT_BITS(16)) dut_gsh (
    .Clock(Clock), .Reset_n(Reset_n), .Lookup_Addr(lookup_addr), .Prediction(pred_g),
    .Lookup_GHR(ghr_g), .Update_Valid(update_valid), .Update_Addr(update_addr),
    .Update_GHR(update_ghr), .Update_Pred(update_pred), .Update_Taken(update_taken),
    .Stat_Clear(stat_clear), .Ready(ready_g), .Mispredict(misp_g), .Mispredict_Count(cnt_g)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic upd(input logic [31:0] a, input logic [3:0] g, input logic p, input logic t);
    update_valid = 1'b1;
    update_addr  = a;
    update_ghr   = g;
    update_pred  = p;
    update_taken = t;
    tick();
    update_valid = 1'b0;
  endtask

  task automatic wait_ready(output int unsigned n);
    n = 0;
    while (!ready_b && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic look(input string tag, input logic [31:0] a, input logic exp);
    lookup_addr = a;
    #1;
    check(tag, pred_b, exp);
  endtask

  initial begin
    int unsigned n;
    // 1: reset defaults and sweep length
    #1 Reset_n = 1'b0;
    #1;
    check("rst_ready", ready_b, 0);
    check("rst_cnt", cnt_b, 0);
    check("rst_misp", misp_b, 0);
    check("rst_ghr", ghr_b, 0);
    tick();
    Reset_n = 1'b1;
    lookup_addr = 32'h3;
    tick(); tick(); tick();
    check("init_pred", pred_b, 1);
    check("init_ready", ready_b, 0);
    wait_ready(n);
    check("sweep_len", n + 3, 16);
    check("ready_g", ready_g, 1);
    look("run_pred_0", 32'h0, 1);
    look("run_pred_f", 32'hF, 1);
    look("run_pred_x", 32'h1234_5678, 1);

    // 2: bimodal saturation on entry 5
    upd(32'h5, 4'h0, 1, 0); look("nt1", 32'h5, 0);
    upd(32'h5, 4'h0, 0, 0); look("nt2", 32'h5, 0);
    upd(32'h5, 4'h0, 0, 0); look("nt3", 32'h5, 0);
    upd(32'h5, 4'h0, 0, 1); look("t1", 32'h5, 0);
    upd(32'h5, 4'h0, 0, 1); look("t2", 32'h5, 1);

    // 3: updates during INIT are ignored (entry 2 is already swept by then)
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    tick(); tick(); tick(); tick();
    upd(32'h2, 4'h0, 1, 0);
    upd(32'h2, 4'h0, 1, 0);
    upd(32'h3, 4'h0, 0, 1);
    check("init_upd_misp", misp_b, 0);
    check("init_upd_ghr", ghr_b, 0);
    wait_ready(n);
    check("init_upd_ready", ready_b, 1);
    look("init_upd_pred", 32'h2, 1);
    check("init_upd_cnt", cnt_b, 0);

    // 5: same-cycle lookup/update on an entry at 01
    upd(32'h7, 4'h0, 1, 0);
    lookup_addr  = 32'h7;
    update_valid = 1'b1;
    update_addr  = 32'h7;
    update_pred  = 1'b0;
    update_taken = 1'b1;
    #1;
    check("bypass_old", pred_b, 0);
    tick();
    update_valid = 1'b0;
    check("bypass_new", pred_b, 1);
    check("misp_pulse", misp_b, 1);
    tick();
    check("misp_clear", misp_b, 0);
    check("cnt_two", cnt_b, 2);

    // 6: statistics counter saturation and clear priority
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    check("clear", cnt_b, 0);
    update_valid = 1'b1;
    update_addr  = 32'hA;
    update_pred  = 1'b1;
    update_taken = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 3) check("cnt_lag", cnt_b, 2);
    end
    update_valid = 1'b0;
    tick(); tick();
    check("cnt_sat", cnt_b, 4'hF);
    upd(32'hA, 4'h0, 1, 0);
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    check("clear_wins", cnt_b, 0);
    tick();
    check("clear_hold", cnt_b, 0);

    // Reset mid-RUN then mid-INIT: sweep restarts from index 0
    Reset_n = 1'b0;
    #1;
    check("midrun_ready", ready_b, 0);
    tick();
    Reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("midinit_ready", ready_b, 0);
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    wait_ready(n);
    check("restart_len", n, 16);
    look("resweep_a", 32'hA, 1);

    // 4: gshare indexing and GHR shifting
    upd(32'h0, 4'h0, 1, 1);
    upd(32'h0, 4'h1, 1, 1);
    check("ghr_0011", ghr_g, 4'b0011);
    upd(32'h5, 4'b0011, 1, 1);
    check("ghr_0111", ghr_g, 4'b0111);
    upd(32'h5, 4'b0011, 1, 0);
    upd(32'h5, 4'b0011, 1, 0);
    check("ghr_1100", ghr_g, 4'b1100);
    check("ghr_bim", ghr_b, 4'b1100);
    lookup_addr = 32'hA;
    #1;
    check("gsh_e6", pred_g, 0);
    lookup_addr = 32'h9;
    #1;
    check("gsh_e5", pred_g, 1);
    look("bim_e5", 32'h5, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
